// File: rtl/microtile_switch.sv
// microtile_switch: shares one pad set between N_TILES micro-tiles, only one
// of which is clocked and driving outputs at any time.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   sel_in        - requested tile index (asynchronous, synchronised here)
//   ui_in         - shared inputs, routed to the active tile only
//   uo_out        - registered output of the active tile
//   tile_ui_in    - per-tile inputs, slice k = [k*IN_W +: IN_W]
//   tile_uo_out   - per-tile outputs, slice k = [k*OUT_W +: OUT_W]
//   tile_clk_en   - per-tile clock enables for external ICGs
//   tile_rst_n    - per-tile registered active-low resets
//   active_sel    - current or incoming tile index
//   busy          - high whenever a tile change (or bring-up) is in progress
module microtile_switch #(
    parameter int N_TILES       = 4,
    parameter int IN_W          = 8,
    parameter int OUT_W         = 8,
    parameter int STABLE_CYCLES = 3,
    parameter int RST_CYCLES    = 4,
    localparam int SEL_W        = $clog2(N_TILES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [IN_W-1:0]          ui_in,
    output logic [OUT_W-1:0]         uo_out,
    output logic [N_TILES*IN_W-1:0]  tile_ui_in,
    input  logic [N_TILES*OUT_W-1:0] tile_uo_out,
    output logic [N_TILES-1:0]       tile_clk_en,
    output logic [N_TILES-1:0]       tile_rst_n,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     busy
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int HCW = $clog2(RST_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(RST_CYCLES - 1);
    localparam logic [SEL_W:0] N_LIM    = (SEL_W + 1)'(N_TILES);

    typedef enum logic [1:0] {
        ACTIVE,
        QUIESCE,
        OFF,
        HOLD
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_m;
    logic [SEL_W-1:0]   sel_s;
    logic [SCW-1:0]     stab_cnt;
    logic [HCW-1:0]     hold_cnt;
    logic [SEL_W-1:0]   target;
    logic [N_TILES-1:0] sel_hit;
    logic [OUT_W-1:0]   cur_uo;
    logic               accept;

    // Two-flop synchroniser followed by a stability counter. The counter
    // clears on the edge where sel_s takes a new value, so reaching
    // STAB_MAX means sel_s has held for STABLE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_m    <= '0;
            sel_s    <= '0;
            stab_cnt <= '0;
        end else begin
            sel_m <= sel_in;
            sel_s <= sel_m;
            if (sel_m != sel_s)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + SCW'(1);
        end
    end

    assign accept = (state == ACTIVE)
                 && (stab_cnt == STAB_MAX)
                 && (sel_s != active_sel)
                 && ({1'b0, sel_s} < N_LIM);

    always_comb begin
        sel_hit     = '0;
        tile_ui_in  = '0;
        cur_uo      = '0;
        tile_clk_en = '0;
        for (int k = 0; k < N_TILES; k++) begin
            sel_hit[k] = (active_sel == SEL_W'(k));
            if (sel_hit[k]) begin
                cur_uo = tile_uo_out[k*OUT_W +: OUT_W];
                if (state == ACTIVE)
                    tile_ui_in[k*IN_W +: IN_W] = ui_in;
            end
        end
        // Gated by rst_n so enables drop the moment reset asserts and
        // tile 0 is clocked as soon as reset releases.
        if (rst_n && state != OFF)
            tile_clk_en = sel_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            active_sel <= '0;
            target     <= '0;
            tile_rst_n <= '0;
            busy       <= 1'b1;
            uo_out     <= '0;
        end else begin
            uo_out <= (state == ACTIVE) ? cur_uo : '0;
            unique case (state)
                ACTIVE: begin
                    if (accept) begin
                        state      <= QUIESCE;
                        target     <= sel_s;
                        tile_rst_n <= '0;
                        busy       <= 1'b1;
                    end
                end
                QUIESCE: begin
                    state      <= OFF;
                    active_sel <= target;
                end
                OFF: begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_MAX) begin
                        state      <= ACTIVE;
                        busy       <= 1'b0;
                        tile_rst_n <= sel_hit;
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_microtile_switch.sv
// tb_microtile_switch: directed bench for microtile_switch, one default
// instance plus a 3-tile instance for the out-of-range select case.
module tb_microtile_switch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel_in = 2'd0;
    logic [7:0]  ui_in = 8'h5A;
    logic [7:0]  uo_out;
    logic [31:0] tile_ui_in;
    logic [31:0] tile_uo_out = {8'hD4, 8'hC3, 8'hB2, 8'hA5};
    logic [3:0]  tile_clk_en;
    logic [3:0]  tile_rst_n;
    logic [1:0]  active_sel;
    logic        busy;

    logic [1:0]  sel3 = 2'd0;
    logic [7:0]  uo3;
    logic [23:0] tui3;
    logic [23:0] tuo3 = {8'hC3, 8'hB2, 8'hA5};
    logic [2:0]  cen3;
    logic [2:0]  rstn3;
    logic [1:0]  asel3;
    logic        busy3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    microtile_switch dut (
        .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .ui_in(ui_in),
        .uo_out(uo_out), .tile_ui_in(tile_ui_in),
        .tile_uo_out(tile_uo_out), .tile_clk_en(tile_clk_en),
        .tile_rst_n(tile_rst_n), .active_sel(active_sel), .busy(busy)
    );

    microtile_switch #(.N_TILES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel3), .ui_in(ui_in),
        .uo_out(uo3), .tile_ui_in(tui3), .tile_uo_out(tuo3),
        .tile_clk_en(cen3), .tile_rst_n(rstn3),
        .active_sel(asel3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("clk_en_onehot", 32'($countones(tile_clk_en) <= 1), 32'd1);
            chk("rst_n_onehot", 32'($countones(tile_rst_n) <= 1), 32'd1);
        end
    end

    initial begin
        // reset values
        #12;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_cen", tile_clk_en, 4'b0000);
        chk("rst_trst", tile_rst_n, 4'b0000);
        chk("rst_asel", active_sel, 2'd0);
        chk("rst_busy", busy, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_cen", tile_clk_en, 4'b0001);
        repeat (3) tick();
        chk("rel_trst_e3", tile_rst_n, 4'b0000);
        chk("rel_busy_e3", busy, 1'b1);
        tick();
        chk("rel_trst_e4", tile_rst_n, 4'b0001);
        chk("rel_busy_e4", busy, 1'b0);
        chk("rel_ui", tile_ui_in, 32'h0000_005A);
        tick();
        chk("rel_uo", uo_out, 8'hA5);

        // switch 0 -> 2
        sel_in = 2'd2;
        repeat (4) tick();
        chk("sw2_busy_e4", busy, 1'b0);
        tick();
        chk("sw2_busy_e5", busy, 1'b1);
        chk("sw2_q_cen", tile_clk_en, 4'b0001);
        chk("sw2_q_trst", tile_rst_n, 4'b0000);
        chk("sw2_q_ui", tile_ui_in, 32'h0);
        tick();
        chk("sw2_off_cen", tile_clk_en, 4'b0000);
        chk("sw2_off_asel", active_sel, 2'd2);
        tick();
        chk("sw2_hold_cen", tile_clk_en, 4'b0100);
        chk("sw2_hold_trst", tile_rst_n, 4'b0000);
        repeat (3) tick();
        chk("sw2_busy_e10", busy, 1'b1);
        tick();
        chk("sw2_busy_e11", busy, 1'b0);
        chk("sw2_trst_e11", tile_rst_n, 4'b0100);
        chk("sw2_uo_e11", uo_out, 8'h00);
        tick();
        ui_in = 8'h3C;
        #1;
        chk("sw2_uo_e12", uo_out, 8'hC3);
        chk("sw2_ui", tile_ui_in, 32'h003C_0000);

        // glitch of 2 cycles is rejected
        sel_in = 2'd3;
        repeat (2) tick();
        sel_in = 2'd2;
        repeat (3) tick();
        chk("gl_busy_a", busy, 1'b0);
        repeat (3) tick();
        chk("gl_busy_b", busy, 1'b0);
        chk("gl_cen", tile_clk_en, 4'b0100);

        // held select is accepted
        sel_in = 2'd3;
        repeat (4) tick();
        chk("h3_busy_e4", busy, 1'b0);
        tick();
        chk("h3_busy_e5", busy, 1'b1);
        repeat (6) tick();
        chk("h3_busy_e11", busy, 1'b0);
        chk("h3_asel", active_sel, 2'd3);
        chk("h3_trst", tile_rst_n, 4'b1000);

        // change while busy: completes to 1, then goes to 3
        sel_in = 2'd1;
        repeat (6) tick();
        chk("cb_asel_e6", active_sel, 2'd1);
        tick();
        sel_in = 2'd3;
        repeat (4) tick();
        chk("cb_busy_e11", busy, 1'b0);
        chk("cb_asel_e11", active_sel, 2'd1);
        chk("cb_trst_e11", tile_rst_n, 4'b0010);
        tick();
        chk("cb_busy_e12", busy, 1'b1);
        chk("cb_cen_e12", tile_clk_en, 4'b0010);
        tick();
        chk("cb_asel_e13", active_sel, 2'd3);
        repeat (5) tick();
        chk("cb_busy_e18", busy, 1'b0);
        chk("cb_asel_e18", active_sel, 2'd3);

        // out of range on the 3-tile instance
        sel3 = 2'd3;
        repeat (10) tick();
        chk("oor_busy_a", busy3, 1'b0);
        repeat (10) tick();
        chk("oor_busy_b", busy3, 1'b0);
        chk("oor_asel", asel3, 2'd0);
        chk("oor_cen", cen3, 3'b001);
        sel3 = 2'd2;
        repeat (5) tick();
        chk("n3_busy_e5", busy3, 1'b1);

        // reset in the middle of HOLD toward tile 2
        sel_in = 2'd2;
        repeat (8) tick();
        chk("mr_busy_pre", busy, 1'b1);
        chk("mr_cen_pre", tile_clk_en, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("mr_cen", tile_clk_en, 4'b0000);
        chk("mr_trst", tile_rst_n, 4'b0000);
        chk("mr_asel", active_sel, 2'd0);
        chk("mr_busy", busy, 1'b1);
        chk("mr_uo", uo_out, 8'h00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_rel_cen", tile_clk_en, 4'b0001);
        repeat (3) tick();
        chk("mr_busy_r3", busy, 1'b1);
        tick();
        chk("mr_busy_r4", busy, 1'b0);
        chk("mr_asel_r4", active_sel, 2'd0);
        chk("mr_trst_r4", tile_rst_n, 4'b0001);
        tick();
        chk("mr_busy_r5", busy, 1'b1);
        repeat (6) tick();
        chk("mr_busy_r11", busy, 1'b0);
        chk("mr_asel_r11", active_sel, 2'd2);
        chk("mr_trst_r11", tile_rst_n, 4'b0100);
        tick();
        chk("mr_uo_r12", uo_out, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microtile_switch.md
# microtile_switch

Parametrised container for N_TILES micro-tiles sharing one pad set. Only one tile is ever active. Each tile receives a clock enable, a reset and the dedicated inputs; its outputs are muxed onto the shared output bus. The tile select is synchronised and debounced before use. A tile change follows a fixed sequence: quiesce the old tile, a dead cycle, a reset hold on the new tile, then release. This keeps two tiles from being clocked or driving outputs at the same time.

## Interface
- N_TILES, 4, number of tiles (2..16)
- IN_W, 8, input bus width per tile
- OUT_W, 8, output bus width per tile
- SEL_W, $clog2(N_TILES), select width (derived, not overridden)
- STABLE_CYCLES, 3, consecutive cycles a synchronised select must hold before it is accepted (≥1)
- RST_CYCLES, 4, cycles the new tile is held in reset with its clock enabled (≥1)

Ports:
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- sel_in, in, SEL_W, requested tile index, asynchronous to clk
- ui_in, in, IN_W, shared dedicated inputs
- uo_out, out, OUT_W, registered output of the active tile
- tile_ui_in, out, N_TILES*IN_W, per-tile inputs; slice k = bits [k*IN_W +: IN_W]
- tile_uo_out, in, N_TILES*OUT_W, per-tile outputs, same slicing
- tile_clk_en, out, N_TILES, per-tile clock enable, feeding external ICGs
- tile_rst_n, out, N_TILES, per-tile active-low reset, registered
- active_sel, out, SEL_W, index of the current or incoming tile
- busy, out, 1, high whenever state ≠ ACTIVE

## Operation
- **Reset values (rst_n low):**
  - uo_out = 0
  - tile_clk_en = 0
  - tile_rst_n = 0
  - active_sel = 0
  - busy = 1
  - state = HOLD on tile 0, with the hold counter cleared
  - synchroniser and stable counter cleared
- **Select path:**
  - sel_in passes through a 2-FF synchroniser to give sel_s.
  - The stable counter clears when sel_s changes and otherwise increments, saturating.
  - The value is accepted when sel_s has been constant for STABLE_CYCLES cycles.
- **Acceptance conditions:** the value must satisfy all of the following.
  - It differs from active_sel.
  - It is less than N_TILES. Out-of-range values are ignored permanently.
  - State is ACTIVE.
- **FSM states:**
  - ACTIVE:
    - tile_clk_en and tile_rst_n are one-hot at active_sel.
    - An accepted select moves to QUIESCE.
  - QUIESCE, 1 cycle:
    - tile_rst_n[old] = 0.
    - tile_clk_en[old] stays 1 so the tile's synchronous logic sees reset.
    - Moves to OFF.
  - OFF, 1 cycle:
    - All tile_clk_en = 0 and all tile_rst_n = 0.
    - active_sel loads the new index.
    - Moves to HOLD.
  - HOLD, RST_CYCLES cycles:
    - tile_clk_en[new] = 1 and tile_rst_n[new] = 0.
    - Moves to ACTIVE, where tile_rst_n[new] = 1.
- **Input distribution (combinational):**
  - tile_ui_in slice active_sel = ui_in in ACTIVE only.
  - All other slices, and all slices in any other state, are 0.
- **Output:**
  - uo_out is registered from tile_uo_out slice active_sel in ACTIVE, and 0 otherwise.
- **Invariant:** tile_clk_en and tile_rst_n are each at most one-hot every cycle.
- **Select changes while busy:** ignored until ACTIVE is reached. If the debounced select still differs from active_sel at that point, a new switch starts on the next cycle.
- **rst_n asserted mid-sequence:** asynchronously returns to the reset values. The post-reset tile is always tile 0, regardless of sel_in.

## Timing
- sel_in changes between edges E0 and E1 and then holds. With defaults:
  - E1–E2: synchroniser.
  - busy rises after edge E(2+STABLE_CYCLES) = E5, entering QUIESCE.
  - E6: OFF.
  - E7–E10: HOLD.
  - After E11: ACTIVE, tile_rst_n[new] = 1, busy = 0.
  - After E12: uo_out reflects the new tile.
- Total switch latency after acceptance is 2 + RST_CYCLES cycles.
- uo_out latency from tile_uo_out is 1 cycle.
- tile_ui_in has 0-cycle latency.
- After reset release:
  - tile 0 is in HOLD with tile_clk_en[0] = 1 immediately.
  - tile_rst_n[0] rises after RST_CYCLES edges.
  - busy falls on the same edge.

## Test plan
- **Reset release, sel_in = 0:**
  - tile_clk_en = 0001 immediately.
  - tile_rst_n = 0001 after 4 edges; busy falls.
  - With tile_uo_out[0] = 0xA5, uo_out = 0xA5 one cycle later.
  - tile_ui_in slice 0 = ui_in; slices 1–3 = 0.
- **Switch to 2, sel_in 0→2 held:**
  - busy rises after E5; the QUIESCE/OFF/HOLD sequence is as in Timing.
  - tile_clk_en is never two-hot; 0000 in OFF.
  - active_sel = 2 after E6; busy = 0 after E11.
  - uo_out = tile_uo_out[2] after E12.
- **Glitch rejection:**
  - sel_in = 3 for 2 cycles, then back to 0: no busy, no enable change.
  - sel_in = 3 held for 5 cycles: switch occurs.
- **Change during busy:**
  - sel_in 0→1, then →3 during HOLD.
  - The sequence completes to tile 1.
  - One cycle after ACTIVE, QUIESCE starts toward tile 3. Final active_sel = 3.
- **Out of range, N_TILES = 3:**
  - sel_in = 3 held for 20 cycles: busy stays 0 and active_sel is unchanged.
- **Reset mid-HOLD during a switch to tile 2:**
  - All outputs go to reset values asynchronously (before the next edge).
  - After release, tile 0 is brought up even with sel_in = 2, then switches to 2 via the normal sequence.
